// File: rtl/dtw_ref_stream.sv
// Reference-memory read sequencer for the DTW core: issues addresses, absorbs the
// memory's 1-cycle read latency and streams samples through a 4-entry valid/ready buffer.
module dtw_ref_stream #(
   parameter int unsigned WIDTH            = 16,
   parameter int unsigned REFMEM_PTR_WIDTH = 20
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        start_in,
   input  logic                        abort_in,
   input  logic [REFMEM_PTR_WIDTH-1:0] ref_len_in,
   input  logic                        load_done_in,
   output logic [REFMEM_PTR_WIDTH-1:0] ref_read_addr_out,
   input  logic [WIDTH-1:0]            ref_data_in,
   output logic [WIDTH-1:0]            sample_data_out,
   output logic                        sample_valid_out,
   input  logic                        sample_ready_in,
   output logic                        sample_last_out,
   output logic [REFMEM_PTR_WIDTH-1:0] sample_idx_out,
   output logic                        busy_out,
   output logic                        done_out,
   output logic [1:0]                  dbg_state_out
);

   localparam int unsigned PW = REFMEM_PTR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [PW-1:0]    r_len;
   logic [PW-1:0]    r_next_addr;
   logic [PW-1:0]    r_addr;
   logic [PW-1:0]    r_pop_cnt;
   logic             r_iss1;
   logic             r_iss2;
   logic [WIDTH-1:0] r_buf [4];
   logic [1:0]       r_wptr;
   logic [1:0]       r_rptr;
   logic [2:0]       r_occ;
   logic             r_done;

   logic             w_valid;
   logic             w_pop;
   logic             w_push;
   logic [1:0]       w_in_flight;
   logic [3:0]       w_pending;
   logic             w_issue;
   logic [2:0]       w_occ_next;

   // r_iss1: address on the bus this cycle; r_iss2: its data is on ref_data_in now
   always_comb begin
      w_valid     = (r_occ != 3'd0);
      w_pop       = w_valid && sample_ready_in;
      w_push      = r_iss2;
      w_in_flight = {1'b0, r_iss1} + {1'b0, r_iss2};
      w_pending   = 4'(r_occ) + 4'(w_in_flight);
      w_issue     = (r_state == S_FETCH) && (r_next_addr != r_len) && (w_pending < 4'd4);
      w_occ_next  = r_occ + 3'(w_push) - 3'(w_pop);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_next_addr <= '0;
         r_addr      <= '0;
         r_pop_cnt   <= '0;
         r_iss1      <= 1'b0;
         r_iss2      <= 1'b0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_occ       <= '0;
         r_done      <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_in && load_done_in) begin
                  r_pop_cnt <= '0;
                  r_wptr    <= '0;
                  r_rptr    <= '0;
                  r_occ     <= '0;
                  r_iss2    <= 1'b0;
                  if (ref_len_in != '0) begin
                     r_len       <= ref_len_in;
                     r_addr      <= '0;
                     r_next_addr <= PW'(1);
                     r_iss1      <= 1'b1;
                     r_state     <= S_FETCH;
                  end else begin
                     r_iss1  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end

            S_FETCH, S_DRAIN: begin
               if (abort_in) begin
                  r_iss1  <= 1'b0;
                  r_iss2  <= 1'b0;
                  r_wptr  <= '0;
                  r_rptr  <= '0;
                  r_occ   <= '0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_iss1 <= w_issue;
                  r_iss2 <= r_iss1;
                  if (w_issue) begin
                     r_addr      <= r_next_addr;
                     r_next_addr <= r_next_addr + PW'(1);
                  end
                  if (w_push) begin
                     r_buf[r_wptr] <= ref_data_in;
                     r_wptr        <= r_wptr + 2'd1;
                  end
                  if (w_pop) begin
                     r_rptr    <= r_rptr + 2'd1;
                     r_pop_cnt <= r_pop_cnt + PW'(1);
                  end
                  r_occ <= w_occ_next;
                  // Completion needs no data in flight and the buffer empty after this pop
                  if ((r_state == S_FETCH) && (r_next_addr == r_len)) begin
                     r_state <= S_DRAIN;
                  end else if ((r_state == S_DRAIN) && (w_in_flight == 2'd0) &&
                               (w_occ_next == 3'd0)) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      ref_read_addr_out = r_addr;
      sample_valid_out  = w_valid;
      sample_data_out   = r_buf[r_rptr];
      sample_idx_out    = r_pop_cnt;
      sample_last_out   = w_valid && (r_pop_cnt == (r_len - PW'(1)));
      busy_out          = (r_state != S_IDLE);
      done_out          = r_done;
      dbg_state_out     = r_state;
   end

endmodule

// File: tb/tb_dtw_ref_stream.sv
// Directed/randomized bench for dtw_ref_stream: a synchronous-read memory model feeds the
// DUT and every transfer is compared against the memory contents in index order.
module tb_dtw_ref_stream;

   localparam int W  = 16;
   localparam int PW = 6;

   logic          clk;
   logic          rstn;
   logic          start_in;
   logic          abort_in;
   logic [PW-1:0] ref_len_in;
   logic          load_done_in;
   logic [PW-1:0] ref_read_addr_out;
   logic [W-1:0]  ref_data_in;
   logic [W-1:0]  sample_data_out;
   logic          sample_valid_out;
   logic          sample_ready_in;
   logic          sample_last_out;
   logic [PW-1:0] sample_idx_out;
   logic          busy_out;
   logic          done_out;
   logic [1:0]    dbg_state_out;

   logic [W-1:0]  mem [64];
   logic [7:0]    pat;
   int            n_checks;
   int            n_errors;

   dtw_ref_stream #(.WIDTH(W), .REFMEM_PTR_WIDTH(PW)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .start_in          (start_in),
      .abort_in          (abort_in),
      .ref_len_in        (ref_len_in),
      .load_done_in      (load_done_in),
      .ref_read_addr_out (ref_read_addr_out),
      .ref_data_in       (ref_data_in),
      .sample_data_out   (sample_data_out),
      .sample_valid_out  (sample_valid_out),
      .sample_ready_in   (sample_ready_in),
      .sample_last_out   (sample_last_out),
      .sample_idx_out    (sample_idx_out),
      .busy_out          (busy_out),
      .done_out          (done_out),
      .dbg_state_out     (dbg_state_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference memory: data for the presented address appears one cycle later
   always @(posedge clk) ref_data_in <= mem[ref_read_addr_out];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(sample_valid_out), 32'd0);
      check({tag, "_data"},  32'(sample_data_out),  32'd0);
      check({tag, "_idx"},   32'(sample_idx_out),   32'd0);
      check({tag, "_last"},  32'(sample_last_out),  32'd0);
      check({tag, "_addr"},  32'(ref_read_addr_out), 32'd0);
      check({tag, "_busy"},  32'(busy_out),         32'd0);
      check({tag, "_done"},  32'(done_out),         32'd0);
      check({tag, "_state"}, 32'(dbg_state_out),    32'd0);
   endtask

   task automatic fill_mem(input bit ramp);
      for (int i = 0; i < 64; i++) begin
         mem[i] = ramp ? W'(16'h0100 + i) : W'($urandom);
      end
   endtask

   // rmode: 0 ready held high, 1 fixed pattern, 2 random. abort_after / rst_after < 0 disable.
   task automatic run_stream(input int len, input int rmode, input int abort_after,
                             input int rst_after, input bit start_abort);
      int          xfers = 0;
      int          cyc = 1;
      int          first_valid = -1;
      int          last_cyc = -1;
      int          done_cyc = -1;
      int          busy_cyc = 0;
      int          pat_i = 0;
      bit          finished = 0;
      bit          aborting = 0;
      bit          prev_stall = 0;
      bit          was_reset = 0;
      logic [W-1:0]  p_data = '0;
      logic [PW-1:0] p_idx = '0;
      logic          p_last = 1'b0;

      @(negedge clk);
      ref_len_in      = PW'(len);
      load_done_in    = 1'b1;
      start_in        = 1'b1;
      abort_in        = start_abort;
      sample_ready_in = 1'b0;
      @(negedge clk);
      start_in = 1'b0;
      abort_in = 1'b0;

      while (!finished && cyc < 400) begin
         if (busy_out) busy_cyc++;
         if (sample_valid_out && first_valid < 0) first_valid = cyc;
         if (prev_stall) begin
            check("stall_valid", 32'(sample_valid_out), 32'd1);
            check("stall_data",  32'(sample_data_out),  32'(p_data));
            check("stall_idx",   32'(sample_idx_out),   32'(p_idx));
            check("stall_last",  32'(sample_last_out),  32'(p_last));
         end
         prev_stall = 0;
         if (aborting) begin
            check("abort_valid", 32'(sample_valid_out), 32'd0);
            check("abort_done",  32'(done_out),         32'd1);
            abort_in = 1'b0;
            finished = 1;
         end else if (done_out) begin
            done_cyc = cyc;
            finished = 1;
         end else if (abort_after >= 0 && xfers == abort_after) begin
            abort_in        = 1'b1;
            sample_ready_in = 1'b0;
            aborting        = 1;
         end else if (rst_after >= 0 && xfers == rst_after) begin
            rstn = 1'b0;
            #1;
            check_all_zero("midreset");
            was_reset = 1;
            finished  = 1;
         end else begin
            case (rmode)
               0:       sample_ready_in = 1'b1;
               1:       sample_ready_in = pat[pat_i % 8];
               default: sample_ready_in = 1'($urandom_range(0, 1));
            endcase
            pat_i++;
            if (sample_valid_out && sample_ready_in) begin
               check("xfer_data", 32'(sample_data_out), 32'(mem[xfers]));
               check("xfer_idx",  32'(sample_idx_out),  32'(xfers));
               check("xfer_last", 32'(sample_last_out), 32'(xfers == len - 1));
               xfers++;
               last_cyc = cyc;
            end else if (sample_valid_out) begin
               prev_stall = 1;
               p_data     = sample_data_out;
               p_idx      = sample_idx_out;
               p_last     = sample_last_out;
            end
         end
         @(negedge clk);
         cyc++;
      end
      sample_ready_in = 1'b0;
      abort_in        = 1'b0;
      if (was_reset) begin
         rstn = 1'b1;
         return;
      end
      check("stream_end", 32'(finished), 32'd1);
      if (abort_after < 0) begin
         check("xfer_count",  32'(xfers),       32'(len));
         check("done_cycle",  32'(done_cyc),    (len == 0) ? 32'd1 : 32'(last_cyc + 1));
         check("first_valid", 32'(first_valid), (len == 0) ? 32'hFFFF_FFFF : 32'd3);
         if (len == 0) check("len0_busy_cycles", 32'(busy_cyc), 32'd1);
      end
      check("idle_after_busy", 32'(busy_out), 32'd0);
      check("idle_after_done", 32'(done_out), 32'd0);
   endtask

   initial begin
      logic [PW-1:0] saved_addr;
      n_checks        = 0;
      n_errors        = 0;
      pat             = 8'b0110_1001;
      rstn            = 1'b0;
      start_in        = 1'b0;
      abort_in        = 1'b0;
      ref_len_in      = '0;
      load_done_in    = 1'b0;
      sample_ready_in = 1'b0;
      fill_mem(1'b1);
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rstn = 1'b1;
      @(negedge clk);

      run_stream(4, 0, -1, -1, 1'b0);

      fill_mem(1'b0);
      run_stream(8, 1, -1, -1, 1'b0);

      run_stream(0, 0, -1, -1, 1'b0);

      saved_addr      = ref_read_addr_out;
      load_done_in    = 1'b0;
      ref_len_in      = PW'(5);
      start_in        = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("noload_busy",  32'(busy_out),          32'd0);
         check("noload_done",  32'(done_out),          32'd0);
         check("noload_addr",  32'(ref_read_addr_out), 32'(saved_addr));
         check("noload_valid", 32'(sample_valid_out),  32'd0);
         @(negedge clk);
      end

      fill_mem(1'b0);
      run_stream(16, 2, 5, -1, 1'b0);
      run_stream(3, 0, -1, -1, 1'b0);

      run_stream(10, 0, -1, 4, 1'b0);
      @(negedge clk);
      run_stream(10, 2, -1, -1, 1'b0);

      fill_mem(1'b0);
      run_stream(63, 2, -1, -1, 1'b0);
      run_stream(1, 0, -1, -1, 1'b0);
      run_stream(5, 1, -1, -1, 1'b1);
      run_stream(20, 2, 0, -1, 1'b0);
      run_stream(6, 2, -1, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
